bicubic_line_writer: RTL and testbench
======================================

# bicubic_line_writer

Input-side stage of the bicubic upscaler line buffer. Accepts a raster pixel stream (AXI4-Stream style, `tuser` = start of frame, `tlast` = end of line) and packs `PACK` pixels per word. It writes each packed word into port A of the line-buffer SDPRAM as a ring of `LINES` line slots. It tracks slot occupancy against releases from the downstream window reader and stalls the stream when every slot holds an unconsumed line.

## Interface
Parameters:
- `PIXEL_WIDTH`, 24, bits per pixel.
- `PACK`, 2, pixels per RAM word; power of two, ≥1.
- `LINE_WIDTH`, 1920, pixels per line; multiple of `PACK`.
- `LINES`, 4, line slots in the ring; power of two, ≥2.
- Derived, not overridable:
  - `WPL` = `LINE_WIDTH`/`PACK`
  - `WORD_AW` = $clog2(`WPL`)
  - `SLOT_AW` = $clog2(`LINES`)
  - `ADDR_WIDTH` = `SLOT_AW`+`WORD_AW`

Ports:
- `clk`, in, 1, single clock for all logic.
- `areset`, in, 1, asynchronous active-high reset.
- `s_tdata`, in, `PIXEL_WIDTH`, pixel.
- `s_tvalid`, in, 1, pixel valid.
- `s_tready`, out, 1, pixel accepted when `s_tvalid`&`s_tready`.
- `s_tuser`, in, 1, first pixel of frame.
- `s_tlast`, in, 1, last pixel of line.
- `ram_addr`, out, `ADDR_WIDTH`, {slot, word index} to SDPRAM `a_addr`.
- `ram_data`, out, `PIXEL_WIDTH`*`PACK`, packed word to `a_data`.
- `ram_wren`, out, 1, write strobe to `a_wren`.
- `line_release`, in, 1, reader frees the oldest filled slot (one per pulse).
- `line_done`, out, 1, one-cycle pulse: a line has been fully written.
- `line_slot`, out, `SLOT_AW`, slot of the line just completed; valid with `line_done`.
- `lines_used`, out, `SLOT_AW`+1, filled-and-unreleased slot count.
- `frame_start`, out, 1, one-cycle pulse on SOF acceptance.
- `err_short`, out, 1, sticky: `tlast` arrived before `LINE_WIDTH` pixels.
- `err_long`, out, 1, sticky: no `tlast` at pixel `LINE_WIDTH`.

## Operation
- Reset values: all outputs 0, including `s_tready`, `ram_*`, `lines_used`, flags and pulses.
- Internal state: write slot = 0, word index = 0, lane = 0, state `IDLE`.
- States:
  - `IDLE`: `s_tready`=1. Pixels without `s_tuser` are discarded. A pixel accepted with `s_tuser` goes to `ACTIVE` and is stored as lane 0.
  - `ACTIVE`: `s_tready` = (`lines_used` < `LINES`). Each accepted pixel goes into lane `lane`, bits [(lane+1)*PIXEL_WIDTH-1 -: PIXEL_WIDTH]; the first pixel is in the LSBs.
- Word write: when lane `PACK`-1 is accepted, the word is written at {write slot, word index}. Word index then increments and lane returns to 0.
- Line end is the pixel with index `LINE_WIDTH`-1, or an earlier `tlast`. On line end:
  - the (possibly partial, zero-padded) word is written;
  - `line_done`=1 with `line_slot` = write slot;
  - write slot increments mod `LINES`; word index and lane clear.
- Short line (`tlast` early): set `err_short`; the rest of the slot is left stale.
- Long line (pixel `LINE_WIDTH`-1 without `tlast`): set `err_long`; the line ends anyway. Following pixels up to and including the next `tlast` are discarded with `s_tready`=1.
- `s_tuser` accepted in `ACTIVE`:
  - the partial line is abandoned and not written;
  - write slot, word index and lane clear; `lines_used` clears to 0;
  - both error flags clear; `frame_start` pulses;
  - the pixel becomes lane 0 of the new frame.
- Occupancy: `lines_used` +1 on `line_done`, −1 on `line_release`, unchanged when both occur in the same cycle. A release at 0 is ignored. A frame restart takes priority over both.
- Full: in `ACTIVE`, `s_tready` drops while `lines_used`=`LINES`. A release in cycle N makes `s_tready` high in N+1.

## Timing
- All outputs are registered.
- `ram_wren`/`ram_addr`/`ram_data`: one cycle after acceptance of the word-completing pixel; `ram_wren` is a single-cycle pulse.
- `line_done`/`line_slot`: same cycle as the line's final `ram_wren`.
- `lines_used`: updates the cycle after `line_done` is asserted.
- `frame_start`: one cycle after SOF acceptance.
- Throughput: one pixel per cycle when not full; no bubbles between lines or at slot wrap (`LINES`-1 → 0).
- `areset` mid-line: immediate return to reset values; partial data is discarded.

## Test plan
- Nominal: PACK=2, LINE_WIDTH=8, LINES=4, SOF then 8 pixels 0x000001..0x000008 with `tlast` on the 8th.
  - Required: 4 writes at addr 0..3, the first `ram_data`=0x000002_000001.
  - `line_done` with `line_slot`=0; `lines_used`=1.
- Full/stall: 4 lines, no release.
  - Required: `lines_used`=4 and `s_tready`=0 in `ACTIVE`.
  - One `line_release` → `s_tready`=1 the next cycle; the 5th line writes slot 0 (addr 0..3).
- Simultaneous: `line_release` in the same cycle as `line_done` at `lines_used`=2 → stays 2.
- Short line: `tlast` on pixel 3 (index 2).
  - Required: writes at addr 0 and 1, with word 1 = {0, pixel 2}.
  - `err_short`=1; the next line goes to slot 1.
- Long line and mid-frame SOF:
  - 10 pixels, no `tlast` → `err_long`=1 and `line_done` after pixel 8; pixels 9–10 dropped until `tlast`.
  - SOF at pixel 5 of the next line → no write for the partial word, `lines_used`=0, `frame_start` pulse, flags cleared, writes restart at addr 0.
- Async reset asserted mid-word → all outputs 0 in the same cycle; after release, pixels without `s_tuser` are dropped.

Source files
------------

// File: rtl/bicubic_line_writer.sv
// Bicubic upscaler line-buffer writer.
// Packs a raster pixel stream (tuser = SOF, tlast = EOL) into PACK-pixel words
// and writes them into a ring of LINES line slots of the line-buffer SDPRAM.
// Tracks slot occupancy against reader releases and back-pressures when full.
// Ports:
//   clk, areset                   : clock, async active-high reset
//   s_tdata/tvalid/tready/tuser/tlast : pixel stream in
//   ram_addr/ram_data/ram_wren    : SDPRAM port A write
//   line_release                  : reader frees the oldest filled slot
//   line_done/line_slot           : line-complete pulse and its slot
//   lines_used                    : filled-and-unreleased slot count
//   frame_start                   : SOF acceptance pulse
//   err_short/err_long            : sticky line-length error flags
module bicubic_line_writer #(
   parameter int unsigned PIXEL_WIDTH = 24,
   parameter int unsigned PACK        = 2,
   parameter int unsigned LINE_WIDTH  = 1920,
   parameter int unsigned LINES       = 4,
   localparam int unsigned WPL        = LINE_WIDTH / PACK,
   localparam int unsigned WORD_AW    = $clog2(WPL),
   localparam int unsigned SLOT_AW    = $clog2(LINES),
   localparam int unsigned ADDR_WIDTH = SLOT_AW + WORD_AW
) (
   input  logic                          clk,
   input  logic                          areset,
   input  logic [PIXEL_WIDTH-1:0]        s_tdata,
   input  logic                          s_tvalid,
   output logic                          s_tready,
   input  logic                          s_tuser,
   input  logic                          s_tlast,
   output logic [ADDR_WIDTH-1:0]         ram_addr,
   output logic [PIXEL_WIDTH*PACK-1:0]   ram_data,
   output logic                          ram_wren,
   input  logic                          line_release,
   output logic                          line_done,
   output logic [SLOT_AW-1:0]            line_slot,
   output logic [SLOT_AW:0]              lines_used,
   output logic                          frame_start,
   output logic                          err_short,
   output logic                          err_long
);

   localparam int unsigned LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
   localparam int unsigned DATA_W = PIXEL_WIDTH * PACK;
   localparam int unsigned CNT_W  = SLOT_AW + 1;
   localparam int unsigned PEND_W = CNT_W + 1;

   typedef enum logic [1:0] {IDLE, ACTIVE, DROP} state_t;

   state_t               state_q, state_n;
   logic [SLOT_AW-1:0]   slot_q, slot_n, slot_b;
   logic [WORD_AW-1:0]   word_q, word_n, word_b;
   logic [LANE_W-1:0]    lane_q, lane_n, lane_b;
   logic [DATA_W-1:0]    buf_q, buf_n, buf_b;

   logic                 s_tready_n;
   logic [ADDR_WIDTH-1:0] ram_addr_n;
   logic [DATA_W-1:0]    ram_data_n;
   logic                 ram_wren_n;
   logic                 line_done_n;
   logic [SLOT_AW-1:0]   line_slot_n;
   logic [CNT_W-1:0]     lines_used_n;
   logic                 frame_start_n;
   logic                 err_short_n;
   logic                 err_long_n;

   logic                 accept;
   logic                 sof;
   logic                 take;
   logic                 last_px;
   logic                 end_line;
   logic [DATA_W-1:0]    word_v;
   logic [PEND_W-1:0]    pend;

   // State and output registers
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q     <= IDLE;
         slot_q      <= '0;
         word_q      <= '0;
         lane_q      <= '0;
         buf_q       <= '0;
         s_tready    <= 1'b0;
         ram_addr    <= '0;
         ram_data    <= '0;
         ram_wren    <= 1'b0;
         line_done   <= 1'b0;
         line_slot   <= '0;
         lines_used  <= '0;
         frame_start <= 1'b0;
         err_short   <= 1'b0;
         err_long    <= 1'b0;
      end else begin
         state_q     <= state_n;
         slot_q      <= slot_n;
         word_q      <= word_n;
         lane_q      <= lane_n;
         buf_q       <= buf_n;
         s_tready    <= s_tready_n;
         ram_addr    <= ram_addr_n;
         ram_data    <= ram_data_n;
         ram_wren    <= ram_wren_n;
         line_done   <= line_done_n;
         line_slot   <= line_slot_n;
         lines_used  <= lines_used_n;
         frame_start <= frame_start_n;
         err_short   <= err_short_n;
         err_long    <= err_long_n;
      end
   end

   // Next-state: packing, line framing, occupancy and back-pressure
   always_comb begin
      state_n       = state_q;
      slot_n        = slot_q;
      word_n        = word_q;
      lane_n        = lane_q;
      buf_n         = buf_q;
      ram_addr_n    = ram_addr;
      ram_data_n    = ram_data;
      ram_wren_n    = 1'b0;
      line_done_n   = 1'b0;
      line_slot_n   = line_slot;
      lines_used_n  = lines_used;
      frame_start_n = 1'b0;
      err_short_n   = err_short;
      err_long_n    = err_long;
      slot_b        = slot_q;
      word_b        = word_q;
      lane_b        = lane_q;
      buf_b         = buf_q;
      take          = 1'b0;
      last_px       = 1'b0;
      end_line      = 1'b0;
      word_v        = '0;
      pend          = '0;
      s_tready_n    = 1'b1;

      accept = s_tvalid & s_tready;
      sof    = accept & s_tuser;

      if (accept) begin
         unique case (state_q)
            IDLE:    take = s_tuser;
            ACTIVE:  take = 1'b1;
            DROP: begin
               take = s_tuser;
               if (!s_tuser && s_tlast) state_n = ACTIVE;
            end
            default: take = 1'b0;
         endcase
      end

      // SOF abandons any partial line; the pixel then starts the new frame
      if (sof) begin
         state_n       = ACTIVE;
         frame_start_n = 1'b1;
         err_short_n   = 1'b0;
         err_long_n    = 1'b0;
         slot_b        = '0;
         word_b        = '0;
         lane_b        = '0;
         buf_b         = '0;
         slot_n        = '0;
         word_n        = '0;
         lane_n        = '0;
         buf_n         = '0;
      end

      if (take) begin
         word_v = buf_b;
         word_v[lane_b*PIXEL_WIDTH +: PIXEL_WIDTH] = s_tdata;
         last_px  = (word_b == WORD_AW'(WPL - 1)) && (lane_b == LANE_W'(PACK - 1));
         end_line = last_px || s_tlast;

         if (end_line || (lane_b == LANE_W'(PACK - 1))) begin
            ram_wren_n = 1'b1;
            ram_addr_n = {slot_b, word_b};
            ram_data_n = word_v;
         end

         if (end_line) begin
            line_done_n = 1'b1;
            line_slot_n = slot_b;
            slot_n      = slot_b + SLOT_AW'(1);
            word_n      = '0;
            lane_n      = '0;
            buf_n       = '0;
            if (s_tlast && !last_px) err_short_n = 1'b1;
            // Overlong line: close it here and discard up to the next tlast
            if (last_px && !s_tlast) begin
               err_long_n = 1'b1;
               state_n    = DROP;
            end
         end else if (lane_b == LANE_W'(PACK - 1)) begin
            word_n = word_b + WORD_AW'(1);
            lane_n = '0;
            buf_n  = '0;
         end else begin
            lane_n = lane_b + LANE_W'(1);
            buf_n  = word_v;
         end
      end

      // Occupancy follows the registered line_done pulse; restart wins
      if (sof) begin
         lines_used_n = '0;
      end else if (line_done && !line_release) begin
         lines_used_n = lines_used + CNT_W'(1);
      end else if (!line_done && line_release && (lines_used != '0)) begin
         lines_used_n = lines_used - CNT_W'(1);
      end

      // Count a line whose done pulse is still in flight so no slot is overrun
      pend = {1'b0, lines_used_n} + PEND_W'(line_done_n);
      if (state_n == ACTIVE) s_tready_n = (pend < PEND_W'(LINES));
   end

endmodule

// File: tb/tb_bicubic_line_writer.sv
module tb_bicubic_line_writer;

   localparam int unsigned PW  = 24;
   localparam int unsigned PK  = 2;
   localparam int unsigned LW  = 8;
   localparam int unsigned NL  = 4;
   localparam int unsigned AW  = 4;
   localparam int unsigned SAW = 2;
   localparam int unsigned DW  = PW * PK;

   logic            clk = 1'b0;
   logic            areset;
   logic [PW-1:0]   s_tdata;
   logic            s_tvalid;
   logic            s_tready;
   logic            s_tuser;
   logic            s_tlast;
   logic [AW-1:0]   ram_addr;
   logic [DW-1:0]   ram_data;
   logic            ram_wren;
   logic            line_release;
   logic            line_done;
   logic [SAW-1:0]  line_slot;
   logic [SAW:0]    lines_used;
   logic            frame_start;
   logic            err_short;
   logic            err_long;

   always #5 clk = ~clk;

   bicubic_line_writer #(
      .PIXEL_WIDTH(PW), .PACK(PK), .LINE_WIDTH(LW), .LINES(NL)
   ) dut (
      .clk(clk), .areset(areset),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
      .s_tuser(s_tuser), .s_tlast(s_tlast),
      .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
      .line_release(line_release), .line_done(line_done), .line_slot(line_slot),
      .lines_used(lines_used), .frame_start(frame_start),
      .err_short(err_short), .err_long(err_long)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int fs_cnt   = 0;

   logic [AW+DW-1:0] wq[$];
   logic [SAW-1:0]   ldq[$];
   logic [AW+DW-1:0] exp_w;
   logic [SAW-1:0]   exp_s;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: pops expected writes / line completions as they appear
   always @(negedge clk) begin
      if (!areset) begin
         if (ram_wren) begin
            if (wq.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", ram_addr, ram_data);
            end else begin
               exp_w = wq.pop_front();
               check("ram_write", 64'({ram_addr, ram_data}), 64'(exp_w));
            end
         end
         if (line_done) begin
            if (ldq.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_line_done: got slot %0d expected none", line_slot);
            end else begin
               exp_s = ldq.pop_front();
               check("line_slot", 64'(line_slot), 64'(exp_s));
            end
         end
         if (frame_start) fs_cnt++;
      end
   end

   task automatic exp_write(input int addr, input logic [PW-1:0] hi, input logic [PW-1:0] lo);
      wq.push_back({AW'(addr), hi, lo});
   endtask

   task automatic exp_line(input int slot, input logic [PW-1:0] base);
      for (int w = 0; w < 4; w++)
         exp_write(slot * 4 + w, base + PW'(2 * w + 1), base + PW'(2 * w));
      ldq.push_back(SAW'(slot));
   endtask

   // Called at a negedge; returns at the negedge following acceptance
   task automatic send_px(input logic [PW-1:0] d, input logic u, input logic l);
      int n;
      n = 0;
      s_tdata  = d;
      s_tuser  = u;
      s_tlast  = l;
      s_tvalid = 1'b1;
      while (!s_tready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!s_tready) begin
         n_checks++;
         n_fail++;
         $display("FAIL ready_timeout: got s_tready 0 for %0d cycles expected 1", n);
      end
      @(negedge clk);
      s_tvalid = 1'b0;
      s_tuser  = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic send_line(input int slot, input logic [PW-1:0] base, input logic sof);
      exp_line(slot, base);
      for (int i = 0; i < 8; i++)
         send_px(base + PW'(i), (i == 0) ? sof : 1'b0, (i == 7) ? 1'b1 : 1'b0);
   endtask

   task automatic release_pulse();
      line_release = 1'b1;
      @(negedge clk);
      line_release = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      areset       = 1'b1;
      s_tdata      = '0;
      s_tvalid     = 1'b0;
      s_tuser      = 1'b0;
      s_tlast      = 1'b0;
      line_release = 1'b0;
      repeat (2) @(negedge clk);

      // Reset values
      check("rst_tready", 64'(s_tready), 64'd0);
      check("rst_wren", 64'(ram_wren), 64'd0);
      check("rst_addr", 64'(ram_addr), 64'd0);
      check("rst_data", 64'(ram_data), 64'd0);
      check("rst_line_done", 64'(line_done), 64'd0);
      check("rst_lines_used", 64'(lines_used), 64'd0);
      check("rst_frame_start", 64'(frame_start), 64'd0);
      check("rst_errs", 64'({err_short, err_long}), 64'd0);
      areset = 1'b0;
      @(negedge clk);
      check("idle_tready", 64'(s_tready), 64'd1);

      // Nominal line: addr 0..3, first word 0x000002_000001
      send_line(0, 24'h000001, 1'b1);
      repeat (2) @(negedge clk);
      check("nominal_used", 64'(lines_used), 64'd1);

      // Fill the ring, then stall
      send_line(1, 24'h000010, 1'b0);
      send_line(2, 24'h000020, 1'b0);
      send_line(3, 24'h000030, 1'b0);
      repeat (2) @(negedge clk);
      check("full_used", 64'(lines_used), 64'd4);
      check("full_tready", 64'(s_tready), 64'd0);
      release_pulse();
      check("release_tready", 64'(s_tready), 64'd1);
      check("release_used", 64'(lines_used), 64'd3);
      send_line(0, 24'h000040, 1'b0);
      repeat (2) @(negedge clk);
      check("wrap_used", 64'(lines_used), 64'd4);

      // Release coinciding with line_done keeps the count
      release_pulse();
      release_pulse();
      check("pre_sim_used", 64'(lines_used), 64'd2);
      send_line(1, 24'h000050, 1'b0);
      check("sim_line_done", 64'(line_done), 64'd1);
      release_pulse();
      @(negedge clk);
      check("sim_used", 64'(lines_used), 64'd2);

      // Short line in a fresh frame
      exp_write(0, 24'h000062, 24'h000061);
      exp_write(1, 24'h000000, 24'h000063);
      ldq.push_back(SAW'(0));
      send_px(24'h000061, 1'b1, 1'b0);
      send_px(24'h000062, 1'b0, 1'b0);
      send_px(24'h000063, 1'b0, 1'b1);
      @(negedge clk);
      check("short_err", 64'({err_short, err_long}), 64'b10);
      send_line(1, 24'h000070, 1'b0);
      repeat (2) @(negedge clk);
      check("short_next_used", 64'(lines_used), 64'd2);

      // Long line: closed at pixel 8, pixels 9-10 dropped
      exp_line(2, 24'h000080);
      for (int i = 0; i < 10; i++)
         send_px(24'h000080 + PW'(i), 1'b0, (i == 9) ? 1'b1 : 1'b0);
      @(negedge clk);
      check("long_err", 64'({err_short, err_long}), 64'b11);
      check("long_used", 64'(lines_used), 64'd3);

      // Mid-line SOF at pixel 5: completed words only, then restart at addr 0
      exp_write(12, 24'h000092, 24'h000091);
      exp_write(13, 24'h000094, 24'h000093);
      for (int i = 0; i < 4; i++)
         send_px(24'h000091 + PW'(i), 1'b0, 1'b0);
      exp_line(0, 24'h0000A5);
      send_px(24'h0000A5, 1'b1, 1'b0);
      check("sof_used", 64'(lines_used), 64'd0);
      check("sof_pulse", 64'(frame_start), 64'd1);
      check("sof_errs", 64'({err_short, err_long}), 64'd0);
      for (int i = 1; i < 8; i++)
         send_px(24'h0000A5 + PW'(i), 1'b0, (i == 7) ? 1'b1 : 1'b0);
      repeat (2) @(negedge clk);
      check("sof_line_used", 64'(lines_used), 64'd1);

      // Asynchronous reset mid-word
      send_px(24'h0000B0, 1'b0, 1'b0);
      #2 areset = 1'b1;
      #1;
      check("arst_tready", 64'(s_tready), 64'd0);
      check("arst_used", 64'(lines_used), 64'd0);
      check("arst_outs", 64'({ram_wren, line_done, frame_start, err_short, err_long}), 64'd0);
      check("arst_data", 64'({ram_addr, ram_data, line_slot}), 64'd0);
      @(negedge clk);
      areset = 1'b0;
      @(negedge clk);
      send_px(24'h0000B1, 1'b0, 1'b0);
      send_px(24'h0000B2, 1'b0, 1'b0);
      send_px(24'h0000B3, 1'b0, 1'b1);
      @(negedge clk);
      check("drop_used", 64'(lines_used), 64'd0);
      send_line(0, 24'h0000C0, 1'b1);
      repeat (3) @(negedge clk);
      check("post_rst_used", 64'(lines_used), 64'd1);

      check("writes_drained", 64'(wq.size()), 64'd0);
      check("line_done_drained", 64'(ldq.size()), 64'd0);
      check("frame_start_count", 64'(fs_cnt), 64'd4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
